// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back/write-allocate line cache, tree-PLRU, invalid-way-first victims.
// Hits ack combinationally in IDLE; misses run WB (if dirty) then FILL and retry. CACHE_PERF_CNT_EN adds counters.
module cache_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 28 - IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_stb,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_adr,
  input  logic [15:0]  cpu_sel,
  input  logic [127:0] cpu_dat_m,
  output logic [127:0] cpu_dat_s,
  output logic         cpu_ack,
  output logic         cpu_rty,
  output logic         mem_stb,
  output logic         mem_cyc,
  output logic         mem_we,
  output logic [31:0]  mem_adr,
  output logic [15:0]  mem_sel,
  output logic [127:0] mem_dat_m,
  input  logic [127:0] mem_dat_s,
  input  logic         mem_ack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output logic [31:0]  wb_cnt
`endif
);

  localparam int LVL   = $clog2(WAYS);
  localparam int WAY_W = LVL;
  localparam int PL_IW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_e;

  state_e              state_q;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-2:0]     plru_q  [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [127:0]        data_q  [SETS][WAYS];
  logic [WAY_W-1:0]    vic_q;
  logic [TAG_W-1:0]    rtag_q;
  logic [IDX_W-1:0]    ridx_q;
  logic                mem_stb_q, mem_we_q;
  logic [31:0]         mem_adr_q;
  logic [127:0]        mem_dat_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [WAYS-1:0]     way_hit;
  logic                hit;
  logic [WAY_W-1:0]    hit_way, vict;
  logic [127:0]        hit_line, merged, sel_mask;
  logic                unused_lsb;

  // Walk from the root following each node bit; a 0 bit steers toward the lower-indexed half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    logic             b;
    int               n;
    v = '0;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      b = bits[PL_IW'(n)];
      v = (v << 1) | WAY_W'(b);
      n = 2 * n + 1 + int'(b);
    end
    return v;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  t;
    logic [WAY_W-1:0] sh;
    logic             b;
    int               n;
    t = bits;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      sh = way >> (LVL - 1 - l);
      b  = sh[0];
      t[PL_IW'(n)] = ~b;
      n = 2 * n + 1 + int'(b);
    end
    return t;
  endfunction

  assign req_tag    = cpu_adr[31:4+IDX_W];
  assign req_idx    = cpu_adr[4+IDX_W-1:4];
  assign unused_lsb = ^cpu_adr[3:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign way_hit[g] = valid_q[req_idx][g] && (tag_q[req_idx][g] == req_tag);
  end

  for (genvar g = 0; g < 16; g++) begin : g_mask
    assign sel_mask[8*g +: 8] = {8{cpu_sel[g]}};
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  // Lowest-indexed invalid way overrides the PLRU choice.
  always_comb begin
    vict = plru_victim(plru_q[req_idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vict = WAY_W'(w);
    end
  end

  assign hit       = |way_hit;
  assign hit_line  = data_q[req_idx][hit_way];
  assign merged    = (hit_line & ~sel_mask) | (cpu_dat_m & sel_mask);
  assign cpu_ack   = (state_q == S_IDLE) && cpu_stb && hit && !rst;
  assign cpu_dat_s = cpu_ack ? hit_line : '0;
  assign cpu_rty   = cpu_stb & ~cpu_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_stb_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      vic_q     <= '0;
      rtag_q    <= '0;
      ridx_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[IDX_W'(s)] <= '0;
        dirty_q[IDX_W'(s)] <= '0;
        plru_q[IDX_W'(s)]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (cpu_stb) begin
          if (hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            if (cpu_we) dirty_q[req_idx][hit_way] <= 1'b1;
          end else begin
            vic_q     <= vict;
            rtag_q    <= req_tag;
            ridx_q    <= req_idx;
            mem_stb_q <= 1'b1;
            if (valid_q[req_idx][vict] && dirty_q[req_idx][vict]) begin
              state_q   <= S_WB;
              mem_we_q  <= 1'b1;
              mem_adr_q <= {tag_q[req_idx][vict], req_idx, 4'h0};
              mem_dat_q <= data_q[req_idx][vict];
            end else begin
              state_q   <= S_FILL;
              mem_we_q  <= 1'b0;
              mem_adr_q <= {req_tag, req_idx, 4'h0};
            end
          end
        end
        S_WB: if (mem_ack) begin
          dirty_q[ridx_q][vic_q] <= 1'b0;
          state_q   <= S_FILL;
          mem_we_q  <= 1'b0;
          mem_adr_q <= {rtag_q, ridx_q, 4'h0};
        end
        S_FILL: if (mem_ack) begin
          valid_q[ridx_q][vic_q] <= 1'b1;
          dirty_q[ridx_q][vic_q] <= 1'b0;
          state_q   <= S_IDLE;
          mem_stb_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line payload and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cpu_ack && cpu_we) data_q[req_idx][hit_way] <= merged;
      if (state_q == S_FILL && mem_ack) begin
        data_q[ridx_q][vic_q] <= mem_dat_s;
        tag_q[ridx_q][vic_q]  <= rtag_q;
      end
    end
  end

  assign mem_stb   = mem_stb_q;
  assign mem_cyc   = mem_stb_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_sel   = 16'hFFFF;
  assign mem_dat_m = mem_dat_q;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (cpu_ack) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_IDLE && cpu_stb && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == S_WB && mem_ack) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: randomized + directed bench for cache_nway (WAYS=4, SETS=16) against a timestamp-based replacement model.
// Memory responder acks after a programmable number of wait cycles.
module tb_cache_nway;
  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_stb = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_adr = '0;
  logic [15:0]  cpu_sel = '0;
  logic [127:0] cpu_dat_m = '0;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack, cpu_rty;
  logic         mem_stb, mem_cyc, mem_we;
  logic [31:0]  mem_adr;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat_m;
  logic [127:0] mem_dat_s = '0;
  logic         mem_ack = 1'b0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_sel(cpu_sel),
    .cpu_dat_m(cpu_dat_m), .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack), .cpu_rty(cpu_rty),
    .mem_stb(mem_stb), .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_sel(mem_sel), .mem_dat_m(mem_dat_m), .mem_dat_s(mem_dat_s), .mem_ack(mem_ack)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory and transaction log
  typedef struct packed {
    logic         we;
    logic [31:0]  adr;
    logic [127:0] dat;
  } txn_t;

  logic [127:0] bmem [logic [27:0]];
  txn_t         txq [$];
  int           mem_lat = 0;
  int           wait_cnt = 0;
  logic         wb100_seen = 1'b0;

  function automatic logic [127:0] bmem_rd(input logic [27:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {4{a, 4'h0}} ^ {4{32'h9E37_79B9}};
  endfunction

  always @(negedge clk) begin
    txn_t t;
    mem_ack = 1'b0;
    if (mem_stb && !rst) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          bmem[mem_adr[31:4]] = mem_dat_m;
          if (mem_adr == 32'h100) wb100_seen = 1'b1;
        end else begin
          mem_dat_s = bmem_rd(mem_adr[31:4]);
        end
        t.we  = mem_we;
        t.adr = mem_adr;
        t.dat = mem_we ? mem_dat_m : mem_dat_s;
        txq.push_back(t);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Reference model: replacement follows per-way last-use timestamps
  logic             m_valid [SETS][WAYS];
  logic             m_dirty [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  logic [127:0]     m_data  [SETS][WAYS];
  int unsigned      m_use   [SETS][WAYS];
  int unsigned      tstamp = 0;
  int unsigned      e_hit = 0, e_miss = 0, e_wb = 0;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_use[s][w]   = 0;
      end
    end
    e_hit = 0; e_miss = 0; e_wb = 0;
  endfunction

  function automatic int unsigned max_use(input int s, input int lo, input int n);
    int unsigned m = 0;
    for (int w = lo; w < lo + n; w++) if (m_use[s][w] > m) m = m_use[s][w];
    return m;
  endfunction

  // Victim: first invalid way, else descend into the half whose newest access is older.
  function automatic int m_victim(input int s);
    int lo = 0;
    int n  = WAYS;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    while (n > 1) begin
      if (max_use(s, lo, n / 2) > max_use(s, lo + n / 2, n / 2)) lo += n / 2;
      n = n / 2;
    end
    return lo;
  endfunction

  function automatic logic [127:0] sel_mask(input logic [15:0] sel);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

  task automatic check_counters();
`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, e_hit);
    check("miss_cnt", miss_cnt, e_miss);
    check("wb_cnt", wb_cnt, e_wb);
`endif
  endtask

  task automatic access(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                        input logic [127:0] wd, output logic [127:0] rd, output int lat);
    int               s, hw, v, n_exp, stb_n, cyc, exp_lat, exp_stb;
    logic [TAG_W-1:0] tg;
    logic             got, rty0;
    logic [127:0]     exp_rd;
    logic             e_we  [2];
    logic [31:0]      e_adr [2];
    logic [127:0]     e_dat [2];
    s = int'(adr[7:4]);
    tg = adr[31:8];
    hw = -1;
    n_exp = 0;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    if (hw < 0) begin
      v = m_victim(s);
      e_miss++;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        e_we[0] = 1'b1; e_adr[0] = {m_tag[s][v], 4'(s), 4'h0}; e_dat[0] = m_data[s][v];
        n_exp = 1;
        e_wb++;
      end
      e_we[n_exp] = 1'b0; e_adr[n_exp] = {tg, 4'(s), 4'h0}; e_dat[n_exp] = bmem_rd({tg, 4'(s)});
      n_exp++;
      m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_tag[s][v] = tg; m_data[s][v] = e_dat[n_exp-1];
      hw = v;
      exp_stb = n_exp * (mem_lat + 1);
      exp_lat = exp_stb + 1;
    end else begin
      exp_stb = 0;
      exp_lat = 0;
    end
    e_hit++;
    tstamp++;
    m_use[s][hw] = tstamp;
    exp_rd = m_data[s][hw];
    if (we) begin
      m_data[s][hw]  = (exp_rd & ~sel_mask(sel)) | (wd & sel_mask(sel));
      m_dirty[s][hw] = 1'b1;
    end

    txq.delete();
    cpu_we = we; cpu_adr = adr; cpu_sel = sel; cpu_dat_m = wd; cpu_stb = 1'b1;
    got = 1'b0; cyc = 0; stb_n = 0; rd = '0; rty0 = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) rty0 = cpu_rty;
      if (mem_stb) stb_n++;
      if (cpu_ack) begin got = 1'b1; rd = cpu_dat_s; end
      @(posedge clk); #1;
      if (!got) cyc++;
    end
    cpu_stb = 1'b0;
    lat = cyc;
    check("ack_seen", got, 1'b1);
    if (!got) return;
    check("rty_first_cycle", rty0, exp_lat != 0);
    check("ack_latency", cyc, exp_lat);
    check("mem_stb_cycles", stb_n, exp_stb);
    check("txn_count", txq.size(), n_exp);
    for (int i = 0; i < n_exp && i < txq.size(); i++) begin
      check("txn_we", txq[i].we, e_we[i]);
      check("txn_adr", txq[i].adr, e_adr[i]);
      if (e_we[i]) check("wb_data", txq[i].dat, e_dat[i]);
    end
    if (!we) check("read_data", rd, exp_rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [127:0] rd;
  int           lat;
  logic         seen;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_dat_s", cpu_dat_s, '0);
    check("rst_mem_stb", mem_stb, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_adr", mem_adr, '0);
    check("rst_mem_dat_m", mem_dat_m, '0);
    check("mem_sel_const", mem_sel, 16'hFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    check_counters();

    // Cold read, repeat hit, write-merge
    bmem[28'h10] = {16{8'hA5}};
    mem_lat = 0;
    access(1'b0, 32'h100, 16'h0, '0, rd, lat);
    check("cold_data", rd, {16{8'hA5}});
    check("cold_latency", lat, 2);
    access(1'b0, 32'h100, 16'h0, '0, rd, lat);
    check("repeat_hit_latency", lat, 0);
    access(1'b1, 32'h100, 16'h000F, {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEAD_BEEF}, rd, lat);
    access(1'b0, 32'h100, 16'h0, '0, rd, lat);
    check("merge_readback", rd, {{12{8'hA5}}, 32'hDEAD_BEEF});

    // Evict the dirty 0x100 line through set 0
    mem_lat = 1;
    wb100_seen = 1'b0;
    for (int k = 2; k < 10; k++) begin
      if (!wb100_seen) access(1'b0, 32'(k) << 8, 16'h0, '0, rd, lat);
    end
    check("evict_wb_0x100", wb100_seen, 1'b1);
    check_counters();

    // Invalid-first fill then PLRU victim
    mem_lat = 0;
    do_reset();
    for (int k = 0; k < 4; k++) access(1'b0, 32'(k) << 8, 16'h0, '0, rd, lat);
    access(1'b0, 32'h000, 16'h0, '0, rd, lat);
    access(1'b0, 32'h400, 16'h0, '0, rd, lat);
    access(1'b0, 32'h000, 16'h0, '0, rd, lat);
    check("plru_keeps_0x000", lat, 0);
    access(1'b0, 32'h200, 16'h0, '0, rd, lat);
    check("plru_evicted_0x200", lat != 0, 1'b1);

    // Reset while a fill is outstanding
    mem_lat = 6;
    cpu_we = 1'b0; cpu_adr = 32'h900; cpu_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_stb) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rmf_stb_seen", seen, 1'b1);
    rst = 1'b1;
    cpu_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rmf_stb_low", mem_stb, 1'b0);
    @(posedge clk); #1;
    model_reset();
    mem_lat = 0;
    access(1'b0, 32'h900, 16'h0, '0, rd, lat);
    check("rmf_remiss", lat != 0, 1'b1);

    // Reset and request together: no ack
    cpu_adr = 32'h900; cpu_we = 1'b0; cpu_stb = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_stb_noack", cpu_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_stb = 1'b0;
    model_reset();
    check_counters();

    // Randomized traffic on a few sets with conflicting tags
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      mem_lat = $urandom_range(0, 2);
      access(1'($urandom_range(0, 1)), a, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, rd, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    check_counters();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
